// File: rtl/ror_pkg.sv
// Shared types and widths for the ROR controller, its feeder and the outlier drain.
package ror_pkg;

    localparam int unsigned N      = 16;
    localparam int unsigned ADDR_W = 16;

    typedef struct packed {
        logic [N-1:0] x;
        logic [N-1:0] y;
        logic [N-1:0] z;
    } point_t;

    typedef struct packed {
        logic [ADDR_W-1:0] index;
        point_t            pt;
        logic              last;
    } obuf_entry_t;

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StFlush,
        StDone
    } drain_state_e;

    function automatic logic [ADDR_W-1:0] sat_inc(input logic [ADDR_W-1:0] v);
        return (&v) ? v : v + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/drain_obuf.sv
// Small synchronous FIFO holding {index, point, last} beats ahead of the output port.
module drain_obuf
    import ror_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  obuf_entry_t   push_data,
    input  logic          pop,
    output obuf_entry_t   head,
    output logic [CW-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    obuf_entry_t   mem_q [DEPTH];
    logic          push_ok, pop_ok;

    assign push_ok = push && (count_q != FULL);
    assign pop_ok  = pop && (count_q != '0);

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/outlier_drain.sv
// Drains the controller's outlier-index FIFO, fetches each point's coordinates and
// streams {index, x, y, z, last} beats on a valid/ready port.
module outlier_drain
    import ror_pkg::*;
#(
    parameter int unsigned OBUF_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ctrl_done,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    input  logic [ADDR_W-1:0] fifo_data,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [N-1:0]      mem_x,
    input  logic [N-1:0]      mem_y,
    input  logic [N-1:0]      mem_z,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_index,
    output logic [N-1:0]      out_x,
    output logic [N-1:0]      out_y,
    output logic [N-1:0]      out_z,
    output logic              out_last,
    output logic              drain_done,
    output logic [ADDR_W-1:0] outlier_count
);

    localparam int unsigned CW = $clog2(OBUF_DEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW + 1)'(OBUF_DEPTH);

    drain_state_e      state_q, state_d;
    logic              s1_vld_q, s2_vld_q;
    logic [ADDR_W-1:0] s2_index_q;
    logic              s2_last_q;
    logic              last_seen_q;
    logic [ADDR_W-1:0] outlier_count_q;

    logic [CW-1:0]     obuf_count;
    logic [CW:0]       in_use;
    obuf_entry_t       push_data, head;
    logic              capture_last, beat, frame_clr;

    // Every entry either buffered or still in S1/S2 holds a buffer slot, so a read is
    // only issued when a slot is guaranteed free on arrival.
    assign in_use = {1'b0, obuf_count} + (CW + 1)'(s1_vld_q) + (CW + 1)'(s2_vld_q);
    assign capture_last = s1_vld_q && fifo_empty;
    assign fifo_rd = (state_q == StDrain) && !fifo_empty && !last_seen_q && (in_use < CREDITS);
    assign beat = out_valid && out_ready;

    always_comb begin
        state_d   = state_q;
        frame_clr = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ctrl_done) begin
                    state_d = fifo_empty ? StDone : StDrain;
                end
            end
            StDrain: begin
                if (capture_last) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (!s1_vld_q && !s2_vld_q && (obuf_count == '0)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!ctrl_done) begin
                    state_d   = StIdle;
                    frame_clr = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q         <= StIdle;
            s1_vld_q        <= 1'b0;
            s2_vld_q        <= 1'b0;
            s2_index_q      <= '0;
            s2_last_q       <= 1'b0;
            last_seen_q     <= 1'b0;
            outlier_count_q <= '0;
        end else begin
            state_q  <= state_d;
            s1_vld_q <= fifo_rd;
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_index_q <= fifo_data;
                s2_last_q  <= fifo_empty;
            end
            if (frame_clr) begin
                last_seen_q <= 1'b0;
            end else if (capture_last) begin
                last_seen_q <= 1'b1;
            end
            if (frame_clr) begin
                outlier_count_q <= '0;
            end else if (beat) begin
                outlier_count_q <= sat_inc(outlier_count_q);
            end
        end
    end

    assign mem_rd_en = s1_vld_q;
    assign mem_addr  = s1_vld_q ? fifo_data : '0;

    assign push_data = '{index: s2_index_q, pt: '{x: mem_x, y: mem_y, z: mem_z}, last: s2_last_q};

    drain_obuf #(
        .DEPTH (OBUF_DEPTH)
    ) u_obuf (
        .clock     (clock),
        .reset     (reset),
        .push      (s2_vld_q),
        .push_data (push_data),
        .pop       (beat),
        .head      (head),
        .count     (obuf_count)
    );

    assign out_valid     = (obuf_count != '0);
    assign out_index     = head.index;
    assign out_x         = head.pt.x;
    assign out_y         = head.pt.y;
    assign out_z         = head.pt.z;
    assign out_last      = head.last;
    assign drain_done    = (state_q == StDone);
    assign outlier_count = outlier_count_q;

endmodule

// File: doc/outlier_drain.md
Name: outlier_drain

Overview:
- Sits directly downstream of the ROR Controller and consumes its outlier-index FIFO once the Controller asserts done.
- For each outlier index, it reads that point's x/y/z from the point-cloud memory read port.
- It streams {index, x, y, z} out on a valid/ready interface and flags the final beat.
- It replaces the bench-side FIFO drain / file-dump logic with synthesizable RTL.

Parameters:
- N, 16, coordinate width per axis.
- ADDR_W, 16, point index width; matches the Controller's outlier_pos / point_pos width.
- OBUF_DEPTH, 4, output buffer entries; power of two, minimum 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low.
- ctrl_done  in  1  Controller done; level.
- fifo_empty  in  1  outlier FIFO empty; registered, updates on the edge that consumes the last word.
- fifo_rd  out  1  outlier FIFO read enable; data appears on fifo_data the following cycle.
- fifo_data  in  ADDR_W  outlier point index.
- mem_rd_en  out  1  point memory read enable.
- mem_addr  out  ADDR_W  point memory address.
- mem_x, mem_y, mem_z  in  N each  memory read data; valid 1 cycle after mem_rd_en.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_index  out  ADDR_W  outlier index.
- out_x, out_y, out_z  out  N each  outlier coordinates.
- out_last  out  1  marks the final outlier beat.
- drain_done  out  1  level; all outliers delivered.
- outlier_count  out  ADDR_W  number of beats accepted this frame.

Behaviour:
- Reset (reset==0 at a clock edge):
  - FSM returns to IDLE.
  - All outputs are 0: fifo_rd, mem_rd_en, mem_addr, out_*, drain_done, outlier_count.
  - The output buffer and in-flight pipeline are cleared.
  - Reset mid-drain discards in-flight entries; FIFO contents are not restored.
- FSM states:
  - IDLE: wait for ctrl_done==1.
    - If fifo_empty, go to DONE (zero outliers).
    - Otherwise go to DRAIN.
  - DRAIN: issue reads (rules below). When a read returns with "empty after read" set, stop issuing and go to FLUSH.
  - FLUSH: no new reads. When the pipeline and output buffer are empty and the last beat has been accepted, go to DONE.
  - DONE: drain_done=1. Hold until ctrl_done==0, then return to IDLE and clear outlier_count (next frame).
- ctrl_done deasserting during DRAIN/FLUSH is ignored; the drain always completes.
- Pipeline:
  - S0 (cycle t): fifo_rd=1.
  - S1 (t+1): capture fifo_data and fifo_empty. Drive mem_addr=fifo_data and mem_rd_en=1.
  - S2 (t+2): write {index, mem_x, mem_y, mem_z, last=captured empty} into the output buffer.
  - Minimum latency from fifo_rd to out_valid is 3 cycles.
- Issue rule: fifo_rd=1 only when all of the following hold:
  - state==DRAIN;
  - !fifo_empty;
  - no pending "last" captured;
  - buffer occupancy + in-flight (S1+S2) < OBUF_DEPTH.
- This credit rule guarantees the buffer never overflows; no pipeline stall logic is needed.
- fifo_rd is never asserted while fifo_empty==1.
- Throughput: 1 beat/cycle sustained when out_ready==1. The occupancy counter handles simultaneous push and pop (net 0).
- Output:
  - out_* always reflect the buffer head.
  - A beat transfers when out_valid && out_ready.
  - Payload is held stable while out_valid && !out_ready.
  - outlier_count increments on each transfer and saturates at 2^ADDR_W-1.
- out_last is set on exactly one beat per non-empty frame. A zero-outlier frame produces no beats.

Decomposition:
- Shared package (ror_pkg): N, ADDR_W, and a typedef point_t {x, y, z} of N-bit fields. The Controller and the feeder use the same package.
- One sub-module, drain_obuf: a synchronous FIFO of OBUF_DEPTH entries, each {index, point_t, last}, with push/pop/count and wrap-around pointers.
- The FSM, credit logic and pipeline live in outlier_drain.

Test Plan:
- Three outliers {5, 9, 200}, memory holds x=index+1, y=index+2, z=index+3, out_ready=1:
  - beats (5,6,7,8), (9,10,11,12), (200,201,202,203) on consecutive cycles;
  - out_last only on 200; drain_done then asserts; outlier_count=3.
- FIFO empty when ctrl_done rises:
  - no fifo_rd and no beats;
  - drain_done=1 within 2 cycles; outlier_count=0.
- Ten outliers, out_ready low for 8 cycles then high:
  - fifo_rd stops once 4 entries are buffered or in flight;
  - no beat is lost or duplicated; order is preserved; payload is stable while stalled.
- out_ready toggling 1,0,1,0 with 6 outliers:
  - 6 beats in order, each accepted exactly once;
  - out_last on the 6th.
- reset driven low for 1 cycle mid-drain, after 2 of 5 beats:
  - all outputs 0 the next cycle; FSM in IDLE;
  - count restarts from 0 when the next ctrl_done arrives.
- DONE state, then ctrl_done falls and rises again with 1 new outlier:
  - drain_done clears;
  - exactly one beat with out_last=1; outlier_count=1.
